hack_mem_arbiter: RTL



---
 rtl/hack_mem_pkg.sv | 22 ++
 rtl/hack_addr_decode.sv | 25 ++
 rtl/hack_mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory arbiter: address map,
// widths and the CPU access target encoding.
package hack_mem_pkg;

  localparam int DATA_W = 16;
  localparam int CPU_AW = 15;
  localparam int RAM_AW = 14;
  localparam int SCR_AW = 13;

  localparam logic [CPU_AW-1:0] RAM_TOP  = 15'h3FFF;
  localparam logic [CPU_AW-1:0] SCR_BASE = 15'h4000;
  localparam logic [CPU_AW-1:0] SCR_TOP  = 15'h5FFF;
  localparam logic [CPU_AW-1:0] KBD_ADDR = 15'h6000;

  typedef enum logic [1:0] {
    TGT_RAM = 2'd0,
    TGT_SCR = 2'd1,
    TGT_KBD = 2'd2,
    TGT_INV = 2'd3
  } tgt_e;

endpackage

// File: rtl/hack_addr_decode.sv
// Combinational decode of a CPU word address into its target and the
// word offset inside that target.
module hack_addr_decode
  import hack_mem_pkg::*;
(
  input  logic [CPU_AW-1:0] cpu_addr,
  output tgt_e              tgt,
  output logic [RAM_AW-1:0] offset
);

  always_comb begin
    tgt = TGT_INV;
    if (cpu_addr <= RAM_TOP) begin
      tgt = TGT_RAM;
    end else if (cpu_addr >= SCR_BASE && cpu_addr <= SCR_TOP) begin
      tgt = TGT_SCR;
    end else if (cpu_addr == KBD_ADDR) begin
      tgt = TGT_KBD;
    end
  end

  // Screen window starts at 0x4000, so its low 13 bits are already the offset.
  assign offset = cpu_addr[RAM_AW-1:0];

endmodule

// File: rtl/hack_mem_arbiter.sv
// Steers CPU accesses to RAM / screen / keyboard and shares the single
// screen port with the video refresh reader, with 1-cycle read return.
module hack_mem_arbiter
  import hack_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [SCR_AW-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              scr_en,
  output logic              scr_we,
  output logic [SCR_AW-1:0] scr_addr,
  output logic [DATA_W-1:0] scr_wdata,
  input  logic [DATA_W-1:0] scr_rdata,
  input  logic [DATA_W-1:0] kbd_in
);

  tgt_e              tgt;
  logic [RAM_AW-1:0] offset;

  hack_addr_decode u_decode (
    .cpu_addr (cpu_addr),
    .tgt      (tgt),
    .offset   (offset)
  );

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              vid_rvalid_q, vid_rvalid_d;
  tgt_e              tag_q, tag_d;
  logic [DATA_W-1:0] kbd_q, kbd_d;

  logic cpu_scr, conflict, cpu_prio, cpu_rd, cpu_scr_xfer;

  // Handshake: a transfer happens in any cycle with req && gnt; requesters
  // hold req until granted, and gnt depends only on req, decode and wait_q.
  always_comb begin
    cpu_scr      = cpu_req && (tgt == TGT_SCR);
    conflict     = cpu_scr && vid_req;
    cpu_prio     = (wait_q == WAIT_W'(MAX_WAIT));
    cpu_gnt      = rst_n && cpu_req && (!conflict || cpu_prio);
    vid_gnt      = rst_n && vid_req && (!conflict || !cpu_prio);
    cpu_rd       = cpu_gnt && !cpu_we;
    cpu_scr_xfer = cpu_gnt && (tgt == TGT_SCR);

    ram_en    = cpu_gnt && (tgt == TGT_RAM);
    ram_we    = ram_en && cpu_we;
    ram_addr  = offset;
    ram_wdata = cpu_wdata;

    scr_en    = cpu_scr_xfer || vid_gnt;
    scr_we    = cpu_scr_xfer && cpu_we;
    scr_addr  = cpu_scr_xfer ? offset[SCR_AW-1:0] : vid_addr;
    scr_wdata = cpu_wdata;

    wait_d = wait_q;
    if (!cpu_req || cpu_gnt) begin
      wait_d = '0;
    end else if (cpu_scr && (wait_q < WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end

    cpu_rvalid_d = cpu_rd;
    vid_rvalid_d = vid_gnt;
    tag_d        = cpu_rd ? tgt : tag_q;
    kbd_d        = (cpu_rd && (tgt == TGT_KBD)) ? kbd_in : kbd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q       <= '0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      tag_q        <= TGT_INV;
      kbd_q        <= '0;
    end else begin
      wait_q       <= wait_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rvalid_q <= vid_rvalid_d;
      tag_q        <= tag_d;
      kbd_q        <= kbd_d;
    end
  end

  // Gating with rst_n hides a read that was granted just before reset asserted.
  always_comb begin
    cpu_rvalid = rst_n && cpu_rvalid_q;
    vid_rvalid = rst_n && vid_rvalid_q;
    cpu_rdata  = '0;
    if (cpu_rvalid) begin
      case (tag_q)
        TGT_RAM: cpu_rdata = ram_rdata;
        TGT_SCR: cpu_rdata = scr_rdata;
        TGT_KBD: cpu_rdata = kbd_q;
        default: cpu_rdata = '0;
      endcase
    end
    vid_rdata = vid_rvalid ? scr_rdata : '0;
  end

endmodule
